// File: rtl/reg_file_debug_dump_ctrl.sv
// Register-file debug dump sequencer: halts the pipeline, reads every register and streams it MSB byte first.
// Optional: define DUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module reg_file_debug_dump_ctrl #(
   parameter int NB_DATA  = 32,
   parameter int NB_REG   = 5,
   parameter int SIZE_REG = 32,
   parameter int NB_BYTE  = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_dump_req,
   input  logic               i_halted,
   output logic               o_halt_req,
   output logic [NB_REG-1:0]  o_address_read_debug,
   input  logic [NB_DATA-1:0] i_data_read_debug,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done
);

   localparam int NUM_BYTES = NB_DATA / NB_BYTE;
   localparam int NB_IDX    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(SIZE_REG - 1);
   localparam logic [NB_IDX-1:0] LAST_BYTE = NB_IDX'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT_WAIT,
      ST_ADDR,
      ST_CAPTURE,
      ST_SEND,
      ST_DONE
`ifdef DUMP_CHECKSUM_EN
      , ST_CHK
`endif
   } state_t;

   state_t              state, state_next;
   logic [NB_REG-1:0]   cnt;
   logic [NB_IDX-1:0]   byte_idx;
   logic [NB_DATA-1:0]  shift_q;
   logic                fire;
   logic                word_end;

   assign fire     = o_tx_valid & i_tx_ready;
   assign word_end = fire && (byte_idx == LAST_BYTE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:      if (i_dump_req) state_next = ST_HALT_WAIT;
         ST_HALT_WAIT: if (i_halted)   state_next = ST_ADDR;
         ST_ADDR:      state_next = ST_CAPTURE;
         ST_CAPTURE:   state_next = ST_SEND;
         ST_SEND: begin
            if (word_end) begin
               if (cnt == LAST_ADDR)
`ifdef DUMP_CHECKSUM_EN
                  state_next = ST_CHK;
`else
                  state_next = ST_DONE;
`endif
               else
                  state_next = ST_ADDR;
            end
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CHK:       if (fire) state_next = ST_DONE;
`endif
         ST_DONE:      state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

`ifdef DUMP_CHECKSUM_EN
   logic [NB_BYTE-1:0] csum;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                        csum <= '0;
      else if (state == ST_IDLE)           csum <= '0;
      else if (state == ST_SEND && fire)   csum <= csum ^ o_tx_data;
   end
`endif

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      o_halt_req = 1'b0;
      o_tx_valid = 1'b0;
      o_tx_data  = '0;
      o_busy     = (state != ST_IDLE);
      o_done     = 1'b0;
      case (state)
         ST_HALT_WAIT, ST_ADDR, ST_CAPTURE: o_halt_req = 1'b1;
         ST_SEND: begin
            o_halt_req = 1'b1;
            o_tx_valid = 1'b1;
            o_tx_data  = shift_q[NB_DATA-1 -: NB_BYTE];
         end
`ifdef DUMP_CHECKSUM_EN
         ST_CHK: begin
            o_halt_req = 1'b1;
            o_tx_valid = 1'b1;
            o_tx_data  = csum;
         end
`endif
         ST_DONE: o_done = 1'b1;
         default: ;
      endcase
   end

   assign o_address_read_debug = cnt;

   // The shift register only moves on an accepted byte, which keeps o_tx_data stable during stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt      <= '0;
         byte_idx <= '0;
         shift_q  <= '0;
      end else begin
         case (state)
            ST_CAPTURE: begin
               shift_q  <= i_data_read_debug;
               byte_idx <= '0;
            end
            ST_SEND: begin
               if (fire) begin
                  shift_q <= shift_q << NB_BYTE;
                  if (byte_idx == LAST_BYTE) begin
                     byte_idx <= '0;
                     if (cnt != LAST_ADDR) cnt <= cnt + 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            ST_DONE: cnt <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_debug_dump_ctrl.sv
// Bench for reg_file_debug_dump_ctrl: a byte scoreboard built from a register-file model, plus halt, stall, reset checks.
module tb_reg_file_debug_dump_ctrl;

   localparam int NB_DATA   = 32;
   localparam int NB_REG    = 5;
   localparam int SIZE_REG  = 32;
   localparam int NB_BYTE   = 8;
   localparam int NUM_BYTES = NB_DATA / NB_BYTE;
`ifdef DUMP_CHECKSUM_EN
   localparam int EXP_LEN = SIZE_REG * NUM_BYTES + 1;
`else
   localparam int EXP_LEN = SIZE_REG * NUM_BYTES;
`endif
   localparam int BUDGET = 6000;

   logic               i_clk;
   logic               i_rst_n;
   logic               i_dump_req;
   logic               i_halted;
   logic               o_halt_req;
   logic [NB_REG-1:0]  o_address_read_debug;
   logic [NB_DATA-1:0] i_data_read_debug;
   logic [NB_BYTE-1:0] o_tx_data;
   logic               o_tx_valid;
   logic               i_tx_ready;
   logic               o_busy;
   logic               o_done;

   logic [NB_DATA-1:0] regs [SIZE_REG];
   logic [NB_BYTE-1:0] exp_q [$];
   int                 n_vec = 0;
   int                 n_mis = 0;
   int                 nbytes = 0;
   int                 done_cnt = 0;
   bit                 stall_mode = 1'b0;

   reg_file_debug_dump_ctrl #(
      .NB_DATA (NB_DATA),
      .NB_REG  (NB_REG),
      .SIZE_REG(SIZE_REG),
      .NB_BYTE (NB_BYTE)
   ) dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_dump_req          (i_dump_req),
      .i_halted            (i_halted),
      .o_halt_req          (o_halt_req),
      .o_address_read_debug(o_address_read_debug),
      .i_data_read_debug   (i_data_read_debug),
      .o_tx_data           (o_tx_data),
      .o_tx_valid          (o_tx_valid),
      .i_tx_ready          (i_tx_ready),
      .o_busy              (o_busy),
      .o_done              (o_done)
   );

   assign i_data_read_debug = regs[o_address_read_debug];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Sink ready: tied high, or the repeating 1,0,0,1 stall pattern.
   initial begin
      int k;
      k = 0;
      i_tx_ready = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         if (stall_mode) begin
            i_tx_ready = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
         end else begin
            i_tx_ready = 1'b1;
         end
      end
   end

   // Stream monitor: pops the scoreboard on each accepted byte and checks data holds across stalls.
   initial begin
      logic               prev_stall;
      logic [NB_BYTE-1:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check("stall_hold", {23'b0, o_tx_valid, o_tx_data}, {23'b0, 1'b1, prev_data});
            if (o_tx_valid && i_tx_ready) begin
               if (exp_q.size() == 0) check("extra_byte", 32'(o_tx_valid), 32'd0);
               else                   check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
               nbytes++;
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_data  = o_tx_data;
            if (o_done) done_cnt++;
         end
      end
   end

   task automatic load_expected();
      logic [NB_BYTE-1:0] csum;
      logic [NB_DATA-1:0] w;
      exp_q.delete();
      csum = '0;
      for (int r = 0; r < SIZE_REG; r++) begin
         w = regs[r];
         for (int b = NUM_BYTES - 1; b >= 0; b--) begin
            exp_q.push_back(w[b*NB_BYTE +: NB_BYTE]);
            csum ^= w[b*NB_BYTE +: NB_BYTE];
         end
      end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(csum);
`endif
      nbytes   = 0;
      done_cnt = 0;
   endtask

   task automatic pulse_req();
      @(posedge i_clk); #1;
      i_dump_req = 1'b1;
      @(posedge i_clk); #1;
      i_dump_req = 1'b0;
      check("halt_after_req", 32'(o_halt_req), 32'd1);
   endtask

   task automatic wait_addr(input logic [NB_REG-1:0] a);
      int n;
      n = 0;
      while (o_address_read_debug != a && n < BUDGET) begin
         @(negedge i_clk);
         n++;
      end
      check("addr_reached", 32'(o_address_read_debug), 32'(a));
   endtask

   task automatic finish_dump(input string tag);
      int n;
      n = 0;
      while (!o_done && n < BUDGET) begin
         @(negedge i_clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(o_done), 32'd1);
      check({tag, "_halt_drop"}, 32'(o_halt_req), 32'd0);
      check({tag, "_busy_in_done"}, 32'(o_busy), 32'd1);
      check({tag, "_pending_at_done"}, 32'(exp_q.size()), 32'd0);
      @(negedge i_clk);
      check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
      repeat (3) @(negedge i_clk);
      check({tag, "_byte_count"}, 32'(nbytes), 32'(EXP_LEN));
      check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_cnt_cleared"}, 32'(o_address_read_debug), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_halt"},  32'(o_halt_req), 32'd0);
      check({tag, "_addr"},  32'(o_address_read_debug), 32'd0);
      check({tag, "_data"},  32'(o_tx_data), 32'd0);
      check({tag, "_valid"}, 32'(o_tx_valid), 32'd0);
      check({tag, "_busy"},  32'(o_busy), 32'd0);
      check({tag, "_done"},  32'(o_done), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n    = 1'b0;
      i_dump_req = 1'b0;
      i_halted   = 1'b0;
      for (int r = 0; r < SIZE_REG; r++) regs[r] = '0;
      regs[2] = 32'h0000_0002;
      regs[3] = 32'h0000_0003;
      repeat (3) @(posedge i_clk);
      #1;
      check_all_zero("in_reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check_all_zero("after_reset");

      // Basic dump: halted immediately, sink always ready.
      i_halted = 1'b1;
      load_expected();
      pulse_req();
      finish_dump("t1");

      // Halt acknowledge delayed by 10 cycles.
      i_halted = 1'b0;
      load_expected();
      pulse_req();
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         check("hw_halt", 32'(o_halt_req), 32'd1);
         check("hw_valid", 32'(o_tx_valid), 32'd0);
         check("hw_addr", 32'(o_address_read_debug), 32'd0);
      end
      @(posedge i_clk); #1;
      i_halted = 1'b1;
      finish_dump("t2");

      // Back-pressure with the 1,0,0,1 ready pattern.
      stall_mode = 1'b1;
      load_expected();
      pulse_req();
      finish_dump("t3");
      stall_mode = 1'b0;

      // A second request mid-dump must be ignored.
      load_expected();
      pulse_req();
      wait_addr(NB_REG'(5));
      @(posedge i_clk); #1;
      i_dump_req = 1'b1;
      @(posedge i_clk); #1;
      i_dump_req = 1'b0;
      finish_dump("t4");

      // Distinct bytes in every register to pin down byte order, with stalls.
      for (int r = 0; r < SIZE_REG; r++) regs[r] = $urandom;
      stall_mode = 1'b1;
      load_expected();
      pulse_req();
      finish_dump("rand");
      stall_mode = 1'b0;

      // Asynchronous reset mid-dump, then a fresh dump from address 0.
      load_expected();
      pulse_req();
      wait_addr(NB_REG'(10));
      @(negedge i_clk);
      #2;
      i_rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_all_zero("async_reset");
      done_cnt = 0;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_no_done", 32'(done_cnt), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("restart_addr", 32'(o_address_read_debug), 32'd0);
      load_expected();
      pulse_req();
      finish_dump("t5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
